// File: rtl/crc_bit_framer.sv
// Byte-to-bit serializer feeding a bit-serial CRC-32/MPEG-2 generator.
// Emits payload bits MSB-first, appends the generator's CRC, then holds off for an inter-packet gap.
module crc_bit_framer #(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  input  logic        byte_last_in,
  output logic        byte_ready_out,
  output logic        bit_out,
  output logic        bit_valid_out,
  output logic        bit_last_out,
  output logic        crc_data_out,
  output logic        crc_valid_out,
  output logic        crc_rst_out,
  input  logic [31:0] crc_in
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DATA, HOLD, CRC, GAP} state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [4:0]       crc_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_flag;
  logic             load;

  // Ready depends only on state: idle, holding, or on the final bit of a non-last byte.
  assign byte_ready_out = (state == IDLE) || (state == HOLD) ||
                          ((state == DATA) && (bit_cnt == 3'd7) && !last_flag);
  assign load           = byte_valid_in && byte_ready_out;

  // CRC bits come straight from the generator: its register only becomes final on the
  // edge that consumes the last data bit, and it is frozen for the whole CRC phase.
  assign crc_data_out = crc_valid_out & shreg[7];
  assign bit_out      = (state == CRC) ? crc_in[crc_idx] : crc_data_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      crc_idx       <= '0;
      gap_cnt       <= '0;
      last_flag     <= 1'b0;
      bit_valid_out <= 1'b0;
      bit_last_out  <= 1'b0;
      crc_valid_out <= 1'b0;
      crc_rst_out   <= 1'b1;
    end else if (load) begin
      state         <= DATA;
      shreg         <= byte_in;
      bit_cnt       <= '0;
      last_flag     <= byte_last_in;
      bit_valid_out <= 1'b1;
      bit_last_out  <= 1'b0;
      crc_valid_out <= 1'b1;
      crc_rst_out   <= 1'b0;
    end else begin
      case (state)
        DATA: begin
          if (bit_cnt != 3'd7) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end else if (last_flag) begin
            state         <= CRC;
            crc_idx       <= 5'd31;
            crc_valid_out <= 1'b0;
          end else begin
            state         <= HOLD;
            bit_valid_out <= 1'b0;
            crc_valid_out <= 1'b0;
          end
        end
        CRC: begin
          if (crc_idx == 5'd0) begin
            state         <= GAP;
            gap_cnt       <= '0;
            bit_valid_out <= 1'b0;
            bit_last_out  <= 1'b0;
          end else begin
            crc_idx      <= crc_idx - 5'd1;
            bit_last_out <= (crc_idx == 5'd1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state       <= IDLE;
            crc_rst_out <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_bit_framer.sv
// Bench for crc_bit_framer: bit-serial CRC generator, byte-level reference model and scoreboard.
module tb_crc_bit_framer;

  localparam int unsigned GAP_CYCLES = 8;
  localparam logic [31:0] POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CHECK_CRC  = 32'h0376_E6E7;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_last_in;
  logic        byte_ready_out;
  logic        bit_out;
  logic        bit_valid_out;
  logic        bit_last_out;
  logic        crc_data_out;
  logic        crc_valid_out;
  logic        crc_rst_out;
  logic [31:0] crc_in;

  crc_bit_framer #(.GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_last_in   (byte_last_in),
    .byte_ready_out (byte_ready_out),
    .bit_out        (bit_out),
    .bit_valid_out  (bit_valid_out),
    .bit_last_out   (bit_last_out),
    .crc_data_out   (crc_data_out),
    .crc_valid_out  (crc_valid_out),
    .crc_rst_out    (crc_rst_out),
    .crc_in         (crc_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic is_data;
    logic b;
    logic last;
  } exp_t;

  int          compares = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          xfer_cnt = 0;
  int          xfer_cyc = 0;
  int          last_cyc = 0;
  int          run_len  = 0;
  int          last_run = 0;
  int          data_cycles = 0;
  logic        chk_en   = 1'b0;
  logic [31:0] gen_crc  = 32'hFFFF_FFFF;
  logic [31:0] pkt_crc  = 32'hFFFF_FFFF;
  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic        obs_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    compares++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Byte-at-a-time CRC-32/MPEG-2 (MSB-first, no reflection, no final xor).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] obs_bits(input int start, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[30:0], obs_q[start + i]};
    return w;
  endfunction

  // Downstream bit-serial CRC generator.
  always @(posedge clk_in) begin
    if (crc_rst_out === 1'b1)
      gen_crc <= 32'hFFFF_FFFF;
    else if (crc_valid_out === 1'b1)
      gen_crc <= {gen_crc[30:0], 1'b0} ^ ((gen_crc[31] ^ crc_data_out) ? POLY : 32'h0);
  end
  assign crc_in = gen_crc;

  // Reference model: every accepted byte owes 8 data bits; a last byte also owes its packet CRC.
  always @(posedge clk_in) begin
    if (rst_in === 1'b1) begin
      exp_q.delete();
      pkt_crc = 32'hFFFF_FFFF;
    end else if (byte_valid_in === 1'b1 && byte_ready_out === 1'b1) begin
      xfer_cnt++;
      xfer_cyc = cyc;
      for (int i = 7; i >= 0; i--) exp_q.push_back('{1'b1, byte_in[i], 1'b0});
      pkt_crc = crc_byte(pkt_crc, byte_in);
      if (byte_last_in) begin
        for (int i = 31; i >= 0; i--) exp_q.push_back('{1'b0, pkt_crc[i], (i == 0)});
        pkt_crc = 32'hFFFF_FFFF;
      end
    end
    cyc++;
  end

  // Per-cycle compare against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("crc_valid_and_rst", 32'(crc_valid_out & crc_rst_out), 32'h0);
      if (crc_valid_out === 1'b1) data_cycles++;
      if (bit_valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_bit");
        end else begin
          cmp_e = exp_q.pop_front();
          chk("bit_out", 32'(bit_out), 32'(cmp_e.b));
          chk("bit_last_out", 32'(bit_last_out), 32'(cmp_e.last));
          chk("crc_valid_out", 32'(crc_valid_out), 32'(cmp_e.is_data));
          chk("crc_rst_busy", 32'(crc_rst_out), 32'h0);
          if (cmp_e.is_data) chk("crc_data_out", 32'(crc_data_out), 32'(cmp_e.b));
        end
        obs_q.push_back(bit_out);
        run_len++;
        if (bit_last_out === 1'b1) begin
          last_run = run_len;
          last_cyc = cyc;
        end
      end else begin
        chk("idle_bit_last", 32'(bit_last_out), 32'h0);
        chk("idle_crc_valid", 32'(crc_valid_out), 32'h0);
        chk("idle_bit_out", 32'(bit_out), 32'h0);
        run_len = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n0;
    int n;
    n0 = xfer_cnt;
    n  = 0;
    byte_in       = b;
    byte_last_in  = last;
    byte_valid_in = 1'b1;
    while (xfer_cnt == n0 && n < 400) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("byte_accepted", 32'(xfer_cnt - n0), 32'h1);
  endtask

  task automatic wait_last();
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      #1;
      n++;
    end while (bit_last_out !== 1'b1 && n < 400);
    if (bit_last_out !== 1'b1) fail("wait_bit_last");
  endtask

  // Called on the bit_last cycle: GAP_CYCLES not-ready cycles, then IDLE with CRC reset.
  task automatic check_gap(input string tag);
    for (int i = 0; i < int'(GAP_CYCLES); i++) begin
      @(negedge clk_in);
      #1;
      chk({tag, "_gap_ready"}, 32'(byte_ready_out), 32'h0);
      chk({tag, "_gap_crc_rst"}, 32'(crc_rst_out), 32'h0);
    end
    @(negedge clk_in);
    #1;
    chk({tag, "_idle_ready"}, 32'(byte_ready_out), 32'h1);
    chk({tag, "_idle_crc_rst"}, 32'(crc_rst_out), 32'h1);
  endtask

  task automatic send_check_string(input string tag, input logic drop_valid);
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), (i == 8));
    if (drop_valid) byte_valid_in = 1'b0;
  endtask

  logic [31:0] snap;
  logic [31:0] model_chk;

  initial begin
    rst_in        = 1'b1;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    byte_last_in  = 1'b0;

    // Model pinned against the published check value.
    model_chk = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) model_chk = crc_byte(model_chk, 8'h31 + 8'(i));
    chk("model_check_value", model_chk, CHECK_CRC);

    repeat (3) @(negedge clk_in);
    chk("rst_ready", 32'(byte_ready_out), 32'h1);
    chk("rst_bit_out", 32'(bit_out), 32'h0);
    chk("rst_bit_valid", 32'(bit_valid_out), 32'h0);
    chk("rst_bit_last", 32'(bit_last_out), 32'h0);
    chk("rst_crc_valid", 32'(crc_valid_out), 32'h0);
    chk("rst_crc_rst", 32'(crc_rst_out), 32'h1);
    rst_in = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_in);

    // 1: "123456789" streamed contiguously.
    obs_q.delete();
    send_byte(8'h31, 1'b0);
    chk("t1_first_valid", 32'(bit_valid_out), 32'h1);
    chk("t1_first_crc_valid", 32'(crc_valid_out), 32'h1);
    chk("t1_first_crc_rst", 32'(crc_rst_out), 32'h0);
    for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i), (i == 8));
    byte_valid_in = 1'b0;
    wait_last();
    chk("t1_bit_count", 32'(obs_q.size()), 32'd104);
    chk("t1_first_byte", obs_bits(0, 8), 32'h31);
    chk("t1_crc", obs_bits(72, 32), CHECK_CRC);
    chk("t1_contiguous_run", 32'(last_run), 32'd104);
    check_gap("t1");

    // 2: same packet with a 5-cycle hold after the third byte.
    obs_q.delete();
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h31 + 8'(i), (i == 8));
      if (i == 2) begin
        byte_valid_in = 1'b0;
        repeat (8) @(posedge clk_in);
        #1;
        snap = crc_in;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_in);
          #1;
          chk("t2_hold_valid", 32'(bit_valid_out), 32'h0);
          chk("t2_hold_ready", 32'(byte_ready_out), 32'h1);
          chk("t2_hold_crc_frozen", crc_in, snap);
        end
      end
    end
    byte_valid_in = 1'b0;
    wait_last();
    chk("t2_bit_count", 32'(obs_q.size()), 32'd104);
    chk("t2_crc", obs_bits(72, 32), CHECK_CRC);
    check_gap("t2");

    // 3: single zero byte.
    obs_q.delete();
    send_byte(8'h00, 1'b1);
    byte_valid_in = 1'b0;
    wait_last();
    chk("t3_bit_count", 32'(obs_q.size()), 32'd40);
    chk("t3_data", obs_bits(0, 8), 32'h0);
    chk("t3_crc_vs_gen", obs_bits(8, 32), gen_crc);
    chk("t3_crc_vs_model", obs_bits(8, 32), crc_byte(32'hFFFF_FFFF, 8'h00));
    check_gap("t3");

    // 4: "12" then "123456789".
    obs_q.delete();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b1);
    byte_valid_in = 1'b0;
    wait_last();
    chk("t4a_crc", obs_bits(16, 32), crc_byte(crc_byte(32'hFFFF_FFFF, 8'h31), 8'h32));
    check_gap("t4a");
    obs_q.delete();
    send_check_string("t4b", 1'b1);
    wait_last();
    chk("t4b_crc", obs_bits(72, 32), CHECK_CRC);
    check_gap("t4b");

    // 5: reset during the CRC phase at index 20.
    obs_q.delete();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b1);
    byte_valid_in = 1'b0;
    repeat (19) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("t5_bits_before_rst", 32'(obs_q.size()), 32'd28);
    chk("t5_in_crc_valid", 32'(bit_valid_out), 32'h1);
    chk("t5_in_crc_crc_valid", 32'(crc_valid_out), 32'h0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("t5_rst_valid", 32'(bit_valid_out), 32'h0);
    chk("t5_rst_ready", 32'(byte_ready_out), 32'h1);
    chk("t5_rst_crc_rst", 32'(crc_rst_out), 32'h1);
    chk("t5_rst_bit_last", 32'(bit_last_out), 32'h0);
    obs_q.delete();
    send_check_string("t5", 1'b1);
    wait_last();
    chk("t5_crc", obs_bits(72, 32), CHECK_CRC);
    check_gap("t5");

    // 6: valid held high through CRC and gap; next packet waits for IDLE.
    obs_q.delete();
    send_check_string("t6a", 1'b0);
    send_byte(8'h31, 1'b0);
    chk("t6_accept_after_gap", 32'(xfer_cyc - last_cyc), 32'(GAP_CYCLES + 1));
    for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i), (i == 8));
    byte_valid_in = 1'b0;
    wait_last();
    chk("t6_bit_count", 32'(obs_q.size()), 32'd208);
    chk("t6a_crc", obs_bits(72, 32), CHECK_CRC);
    chk("t6b_crc", obs_bits(176, 32), CHECK_CRC);
    check_gap("t6");

    repeat (2) @(negedge clk_in);
    chk("xfers_vs_data_bits", 32'(data_cycles), 32'(xfer_cnt * 8));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
